branch_seq_ctrl: RTL

BRANCH_SEQ_CTRL -- requirements
Module: branch_seq_ctrl

---
 rtl/branch_seq_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/branch_seq_ctrl.sv
// Control sequencer for one conditional-branch instruction: fetch (T0..T2),
// opcode check and condition evaluation (T3), PC+offset computation (T4..T6).
module branch_seq_ctrl #(
  parameter logic [4:0]  BR_OPCODE   = 5'b10010,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        con_out,
  input  logic        mem_ready,
  output logic [14:0] ctrl,
  output logic [1:0]  c2,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status
);

  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam int unsigned PC_OUT    = 0;
  localparam int unsigned MAR_IN    = 1;
  localparam int unsigned INC_PC    = 2;
  localparam int unsigned Z_IN      = 3;
  localparam int unsigned Z_LO_OUT  = 4;
  localparam int unsigned PC_IN     = 5;
  localparam int unsigned READ      = 6;
  localparam int unsigned MDR_IN    = 7;
  localparam int unsigned MDR_OUT   = 8;
  localparam int unsigned IR_IN     = 9;
  localparam int unsigned GRA       = 10;
  localparam int unsigned R_OUT     = 11;
  localparam int unsigned CON_IN    = 12;
  localparam int unsigned Y_IN      = 13;
  localparam int unsigned C_OUT_ADD = 14;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          op_ok;
  logic          t1_timeout;
  logic          ir_unused;

  assign op_ok      = (ir[31:27] == BR_OPCODE);
  assign t1_timeout = (state == S_T1) && !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));
  assign ir_unused  = ^{ir[26:21], ir[18:0]};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Counter only runs while parked in T1, so it is implicitly cleared on entry.
  always_ff @(posedge clk) begin
    if (reset || state != S_T1) wait_cnt <= '0;
    else if (!mem_ready)        wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) status <= '0;
        S_T1:   if (t1_timeout) status[2] <= 1'b1;
        S_T3:   if (!op_ok) status[1] <= 1'b1;
        S_T6:   status[0] <= con_out;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1: begin
        if (mem_ready)       state_nxt = S_T2;
        else if (t1_timeout) state_nxt = S_DONE;
      end
      S_T2:   state_nxt = S_T3;
      S_T3:   state_nxt = op_ok ? S_T4 : S_DONE;
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = S_T6;
      S_T6:   state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_T0: begin
        ctrl[PC_OUT] = 1'b1;
        ctrl[MAR_IN] = 1'b1;
        ctrl[INC_PC] = 1'b1;
        ctrl[Z_IN]   = 1'b1;
      end
      S_T1: begin
        // PC load happens only on the first T1 cycle; waits must not reload it.
        ctrl[Z_LO_OUT] = (wait_cnt == '0);
        ctrl[PC_IN]    = (wait_cnt == '0);
        ctrl[READ]     = 1'b1;
        ctrl[MDR_IN]   = mem_ready;
      end
      S_T2: begin
        ctrl[MDR_OUT] = 1'b1;
        ctrl[IR_IN]   = 1'b1;
      end
      S_T3: begin
        ctrl[GRA]    = op_ok;
        ctrl[R_OUT]  = op_ok;
        ctrl[CON_IN] = op_ok;
      end
      S_T4: begin
        ctrl[PC_OUT] = 1'b1;
        ctrl[Y_IN]   = 1'b1;
      end
      S_T5: begin
        ctrl[C_OUT_ADD] = 1'b1;
        ctrl[Z_IN]      = 1'b1;
      end
      S_T6: begin
        ctrl[Z_LO_OUT] = 1'b1;
        ctrl[PC_IN]    = con_out;
      end
      default: ;
    endcase
  end

  assign c2   = ir[20:19];
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule
